// File: rtl/sramlike_axi_bridge.sv
// Sram-like data-port responder: each accepted cache request becomes one
// single-beat AXI3 read or write; one transaction outstanding at a time.
module sramlike_axi_bridge #(
   parameter int unsigned ID_WIDTH = 4,
   parameter int unsigned AXI_ID   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [1:0]          data_size,
   input  logic [31:0]         data_addr,
   input  logic [31:0]         data_wdata,
   output logic [31:0]         data_rdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [ID_WIDTH-1:0] arid,
   output logic [31:0]         araddr,
   output logic [3:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic                arready,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   output logic [ID_WIDTH-1:0] awid,
   output logic [31:0]         awaddr,
   output logic [3:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic                awvalid,
   input  logic                awready,
   output logic [ID_WIDTH-1:0] wid,
   output logic [31:0]         wdata,
   output logic [3:0]          wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;

   state_t      state, state_n;
   logic        wr_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        aw_done, aw_done_n;
   logic        w_done, w_done_n;

   // Responses are always treated as OKAY and every burst is one beat.
   logic unused_resp;
   assign unused_resp = ^{rresp, bresp, rlast};

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_n;
         aw_done <= aw_done_n;
         w_done  <= w_done_n;
         if (state == S_IDLE && data_req) begin
            wr_q    <= data_wr;
            size_q  <= (data_size == 2'b11) ? 2'b10 : data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
         end
      end
   end

   always_comb begin
      state_n   = state;
      aw_done_n = aw_done;
      w_done_n  = w_done;
      case (state)
         S_IDLE: begin
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            if (data_req) state_n = data_wr ? S_AW_W : S_AR;
         end
         S_AR:   if (arready) state_n = S_R;
         S_R:    if (rvalid)  state_n = S_IDLE;
         S_AW_W: begin
            // Address and data channels handshake independently, in either order.
            if (awvalid && awready) aw_done_n = 1'b1;
            if (wvalid && wready)   w_done_n  = 1'b1;
            if (aw_done_n && w_done_n) state_n = S_B;
         end
         S_B:    if (bvalid)  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      case (size_q)
         2'b00:   wstrb = 4'b0001 << addr_q[1:0];
         2'b01:   wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
         default: wstrb = 4'b1111;
      endcase
   end

   assign data_addr_ok = (state == S_IDLE) && data_req;
   assign data_data_ok = ((state == S_R) && rvalid) || ((state == S_B) && bvalid);
   assign data_rdata   = ((state == S_R) && rvalid) ? rdata : '0;

   assign arid    = ID_WIDTH'(AXI_ID);
   assign araddr  = addr_q;
   assign arlen   = '0;
   assign arsize  = {1'b0, size_q};
   assign arburst = 2'b01;
   assign arvalid = (state == S_AR);
   assign rready  = (state == S_R);

   assign awid    = ID_WIDTH'(AXI_ID);
   assign awaddr  = addr_q;
   assign awlen   = '0;
   assign awsize  = {1'b0, size_q};
   assign awburst = 2'b01;
   assign awvalid = (state == S_AW_W) && !aw_done;

   assign wid     = ID_WIDTH'(AXI_ID);
   assign wdata   = wdata_q;
   assign wlast   = 1'b1;
   assign wvalid  = (state == S_AW_W) && !w_done;
   assign bready  = (state == S_B);

endmodule
